// File: rtl/cdc_req_ack_sender.sv
// Sending side of a 4-phase req/ack clock-domain crossing.
// A word is taken from a valid/ready upstream port, then held on data_out
// while req_out runs one full handshake with the far domain. Each handshake
// phase has a watchdog. A timeout in the request phase aborts the transfer,
// and a timeout in the ack-low phase is reported again every TIMEOUT_CYC
// cycles until the far end releases ack.
module cdc_req_ack_sender #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_async,
  output logic              busy,
  output logic              xfer_done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  xfer_count
);

  // The timer never has to hold more than TIMEOUT_CYC-1.
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam bit TMO_EN = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ_HI      = 2'd1,
    WAIT_ACK_LO = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic               ack_s;
  logic [TMR_W-1:0]   timer;
  logic               aborted;
  logic               tmo_hit;

  logic               req_d;
  logic               load_data;
  logic               abort_set;
  logic               tmr_restart;
  logic               done_d;
  logic               terr_d;
  logic               cnt_inc;

  // Synchronize the far-domain acknowledge; only the last stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_async};
    end
  end

  assign ack_s   = ack_sync[SYNC_STAGES-1];
  assign tmo_hit = TMO_EN && (timer == TMR_LAST);

  // Next-state and per-edge actions of the handshake FSM.
  always_comb begin
    state_d     = state;
    req_d       = req_out;
    load_data   = 1'b0;
    abort_set   = 1'b0;
    tmr_restart = 1'b0;
    done_d      = 1'b0;
    terr_d      = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      IDLE: begin
        // A stale ack_s seen here is deliberately ignored.
        if (in_valid) begin
          state_d   = REQ_HI;
          req_d     = 1'b1;
          load_data = 1'b1;
        end
      end
      REQ_HI: begin
        // Acknowledge wins over a simultaneous timeout.
        if (ack_s) begin
          state_d = WAIT_ACK_LO;
          req_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d   = WAIT_ACK_LO;
          req_d     = 1'b0;
          terr_d    = 1'b1;
          abort_set = 1'b1;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = !aborted;
          cnt_inc = !aborted;
        end else if (tmo_hit) begin
          terr_d      = 1'b1;
          tmr_restart = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM state, request line and completion/error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_out     <= 1'b0;
      xfer_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      req_out     <= req_d;
      xfer_done   <= done_d;
      timeout_err <= terr_d;
    end
  end

  // Phase timer: cleared on any state change or periodic restart, runs outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if ((state_d != state) || tmr_restart) begin
      timer <= '0;
    end else if (TMO_EN && (state != IDLE)) begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Aborted flag: set by a request-phase timeout, cleared on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted <= 1'b0;
    end else if (state_d == IDLE) begin
      aborted <= 1'b0;
    end else if (abort_set) begin
      aborted <= 1'b1;
    end
  end

  // Captured word, held unchanged until the handshake finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (load_data) begin
      data_out <= in_data;
    end
  end

  // Count of completed, non-aborted transfers; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (cnt_inc) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;

endmodule

// File: tb/tb_cdc_req_ack_sender.sv
// Testbench for cdc_req_ack_sender: directed handshake scenarios followed by
// randomized traffic with a randomly slow far end, checked every cycle
// against a phase-level behavioural model.
module tb_cdc_req_ack_sender;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 8;
  localparam int CW = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_REQ   = 1;
  localparam int PH_ACKLO = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          ack_async = 1'b0;
  logic          in_ready, req_out, busy, xfer_done, timeout_err;
  logic [DW-1:0] data_out;
  logic [CW-1:0] xfer_count;

  cdc_req_ack_sender #(
    .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .req_out(req_out), .data_out(data_out),
    .ack_async(ack_async), .busy(busy), .xfer_done(xfer_done),
    .timeout_err(timeout_err), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int terr_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks the handshake phase, how long it has been in that phase,
  // and sees ack only after it has crossed SS register delays.
  int            m_ph;
  int            m_age;
  bit            m_abort;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_cnt;
  bit            m_done, m_terr;
  bit            hist [SS];

  task automatic model_reset();
    m_ph = PH_IDLE; m_age = 0; m_abort = 0; m_data = '0; m_cnt = '0;
    m_done = 0; m_terr = 0;
    for (int i = 0; i < SS; i++) hist[i] = 0;
  endtask

  task automatic model_step();
    bit acks;
    int prev;
    acks = hist[SS-1];
    for (int i = SS-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ack_async;
    m_done = 0; m_terr = 0;
    prev = m_ph;
    case (m_ph)
      PH_IDLE: if (in_valid) begin m_data = in_data; m_ph = PH_REQ; end
      PH_REQ: begin
        if (acks) m_ph = PH_ACKLO;
        else if (m_age == TO-1) begin m_terr = 1; m_abort = 1; m_ph = PH_ACKLO; end
      end
      default: begin
        if (!acks) begin
          m_ph = PH_IDLE;
          if (!m_abort) begin m_done = 1; m_cnt = m_cnt + 1'b1; end
          m_abort = 0;
        end else if ((m_age % TO) == TO-1) m_terr = 1;
      end
    endcase
    if (m_ph != prev || m_ph == PH_IDLE) m_age = 0;
    else m_age = m_age + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", in_ready, m_ph == PH_IDLE);
      chk("busy", busy, m_ph != PH_IDLE);
      chk("req_out", req_out, m_ph == PH_REQ);
      chk("data_out", data_out, m_data);
      chk("xfer_done", xfer_done, m_done);
      chk("timeout_err", timeout_err, m_terr);
      chk("xfer_count", xfer_count, m_cnt);
      if (xfer_done === 1'b1) done_seen++;
      if (timeout_err === 1'b1) terr_seen++;
    end
  end

  // ---------------- far end ----------------
  // Mode 0: ack follows req_out after fe_dly cycles. Mode 1: the directed
  // sequence drives ack_async itself.
  int fe_mode = 0;
  int fe_min = 2, fe_max = 2, fe_dly = 2, fe_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (fe_mode == 0) begin
        if (ack_async != req_out) begin
          fe_cnt++;
          if (fe_cnt >= fe_dly) begin
            ack_async = req_out;
            fe_cnt = 0;
            fe_dly = $urandom_range(fe_max, fe_min);
          end
        end else fe_cnt = 0;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic accept(input logic [DW-1:0] d);
    in_valid = 1'b1; in_data = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = DW'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("idle_wait_expired", 1, 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int k, np, d0, t0, n;
    int pt [3];

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req_out", req_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_count", xfer_count, 0);

    // Single transfer, accepted on the first edge after reset release
    rst_n = 1'b1;
    accept(8'hA5);
    chk("single_req_rise", req_out, 1);
    chk("single_capture", data_out, 8'hA5);
    n = 0;
    while (!in_ready && n < 100) begin
      chk("single_hold", data_out, 8'hA5);
      @(negedge clk); n++;
    end
    #1;
    chk("single_done_pulses", done_seen, 1);
    chk("single_count", xfer_count, 1);
    @(negedge clk); #1;

    // Back-to-back words with in_valid held
    in_valid = 1'b1; in_data = 8'h01;
    for (int w = 1; w <= 3; w++) begin
      n = 0;
      while (!in_ready && n < 500) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      chk("b2b_data", data_out, w);
      chk("b2b_ready_low", in_ready, 0);
      if (w < 3) in_data = DW'(w + 1);
      else in_valid = 1'b0;
    end
    wait_idle();
    chk("b2b_count", xfer_count, 4);

    // Request-phase timeout with no ack
    fe_mode = 1; ack_async = 1'b0;
    t0 = terr_seen; d0 = done_seen;
    accept(8'h77);
    k = 0;
    while (k < 20 && timeout_err !== 1'b1) begin @(negedge clk); k++; end
    chk("tmo_latency", k, 8);
    chk("tmo_req_low", req_out, 0);
    @(negedge clk);
    chk("tmo_back_idle", in_ready, 1);
    #1;
    chk("tmo_count", xfer_count, 4);
    chk("tmo_no_done", done_seen - d0, 0);

    // Ack arriving on the timeout edge wins
    t0 = terr_seen; d0 = done_seen;
    accept(8'h55);
    k = 0;
    while (k < 20 && req_out === 1'b1) begin
      @(negedge clk); k++;
      if (k == 5) ack_async = 1'b1;
    end
    chk("prio_req_fall", k, 8);
    ack_async = 1'b0;
    wait_idle();
    chk("prio_no_terr", terr_seen - t0, 0);
    chk("prio_done", done_seen - d0, 1);
    chk("prio_count", xfer_count, 5);

    // Ack stuck high after an abort: repeated timeouts, no completion
    d0 = done_seen;
    accept(8'h66);
    k = 0; np = 0;
    while (k < 60 && np < 3) begin
      @(negedge clk); k++;
      if (k == 6) ack_async = 1'b1;
      if (timeout_err === 1'b1) begin pt[np] = k; np++; end
    end
    chk("stuck_pulses", np, 3);
    chk("stuck_t0", pt[0], 8);
    chk("stuck_t1", pt[1], 16);
    chk("stuck_t2", pt[2], 24);
    ack_async = 1'b0;
    wait_idle();
    chk("stuck_no_done", done_seen - d0, 0);
    chk("stuck_count", xfer_count, 5);

    // Reset in the middle of a request phase
    fe_mode = 0;
    accept(8'h99);
    chk("rstmid_in_req", req_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_req_async", req_out, 0);
    chk("rstmid_ready", in_ready, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_data", data_out, 0);
    chk("rstmid_count", xfer_count, 0);
    chk("rstmid_done", xfer_done, 0);
    chk("rstmid_terr", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    d0 = done_seen;
    accept(8'h42);
    wait_idle();
    chk("rstmid_next_data", data_out, 8'h42);
    chk("rstmid_next_count", xfer_count, 1);

    // Counter wrap: 16 more transfers make 17 since reset
    for (int i = 0; i < 16; i++) begin
      accept(DW'(i + 8'h10));
      wait_idle();
    end
    chk("wrap_count", xfer_count, 1);
    chk("wrap_done_pulses", done_seen - d0, 17);

    // Randomized traffic with a slow, variable far end
    fe_min = 0; fe_max = 11;
    @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      in_valid = ($urandom_range(3, 0) != 0);
      in_data = DW'($urandom);
      if ($urandom_range(799, 0) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
